// File: rtl/axis_master_if_tx_if.sv
// AXI4-Stream bundle (data, last, id, valid/ready) used between the output streamer and the host.
interface axis_master_if_tx_if #(
   parameter int unsigned TdataWidth = 32,
   parameter int unsigned TidWidth   = 2
);
   logic [TdataWidth-1:0] tdata;
   logic                  tlast;
   logic [TidWidth-1:0]   tid;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tlast, output tid, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tid, input tvalid, output tready);
endinterface

// File: rtl/axis_master_if_tx.sv
// AXI4-Stream master: reads output-memory words, buffers them in a small FIFO and serializes
// them MSB slice first. Optional stall statistics are enabled by defining AXIS_TX_STATS_EN.
module axis_master_if_tx #(
   parameter int unsigned        TdataWidth   = 32,
   parameter int unsigned        VlwWidth     = 128,
   parameter int unsigned        MemAddrWidth = 6,
   parameter int unsigned        TidWidth     = 2,
   parameter logic [TidWidth-1:0] OutputId    = 2'b11,
   parameter int unsigned        FifoDepth    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tx_start_i,
   input  logic [MemAddrWidth:0]   tx_len_i,
   output logic                    outputs_mem_rd_en_o,
   output logic [MemAddrWidth-1:0] outputs_mem_addr_o,
   input  logic [VlwWidth-1:0]     outputs_mem_data_i,
   axis_master_if_tx_if.master     m_axis,
   output logic                    outputs_tx_busy_o,
   output logic                    outputs_tx_done_o
`ifdef AXIS_TX_STATS_EN
   ,
   output logic [15:0]             tx_stall_cnt_o
`endif
);

   localparam int unsigned BeatsPerWord = VlwWidth / TdataWidth;
   localparam int unsigned BeatW        = $clog2(BeatsPerWord + 1);
   localparam int unsigned PtrW         = $clog2(FifoDepth);
   localparam int unsigned CntW         = PtrW + 1;
   localparam int unsigned OccW         = CntW + 1;
   localparam int unsigned LenW         = MemAddrWidth + 1;

   typedef enum logic [1:0] {StIdle, StRd, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [LenW-1:0]     len_q, len_d;
   logic [LenW-1:0]     rd_addr_q, rd_addr_d;
   logic                rd_inflight_q;
   logic [LenW-1:0]     words_q, words_d;
   logic [VlwWidth-1:0] fifo_q [FifoDepth];
   logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [VlwWidth-1:0] sr_q, sr_d;
   logic [BeatW-1:0]    beats_q, beats_d;
   logic                sr_last_q, sr_last_d;

   logic                tvalid, tlast, hs, word_end;
   logic                fifo_empty, push, pop, fifo_wr, load, can_load;
   logic [VlwWidth-1:0] load_data;
   logic [OccW-1:0]     occ;
   logic                credit_ok, rd_en, accept, busy, done;

   assign tvalid     = beats_q != '0;
   assign tlast      = sr_last_q && (beats_q == BeatW'(1));
   assign hs         = tvalid && m_axis.tready;
   assign word_end   = hs && (beats_q == BeatW'(1));
   assign fifo_empty = count_q == '0;
   assign push       = rd_inflight_q;

   // An empty FIFO is bypassed so the first word reaches the shifter with no extra cycle.
   assign can_load   = !fifo_empty || push;
   assign load       = can_load && (!tvalid || word_end);
   assign pop        = load && !fifo_empty;
   assign fifo_wr    = push && !(load && fifo_empty);
   assign load_data  = fifo_empty ? outputs_mem_data_i : fifo_q[rptr_q];

   // The word held in the shifter is counted so at most FifoDepth words are ever outstanding.
   assign occ       = OccW'(count_q) + OccW'(rd_inflight_q) + OccW'(tvalid);
   assign credit_ok = occ < OccW'(FifoDepth);

   always_comb begin : p_fsm
      state_d   = state_q;
      len_d     = len_q;
      rd_addr_d = rd_addr_q;
      rd_en     = 1'b0;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tx_start_i && (tx_len_i != '0)) begin
               accept    = 1'b1;
               len_d     = tx_len_i;
               rd_addr_d = '0;
               state_d   = StRd;
            end
         end
         StRd: begin
            busy = 1'b1;
            if (credit_ok) begin
               rd_en     = 1'b1;
               rd_addr_d = rd_addr_q + LenW'(1);
               if (rd_addr_q == (len_q - LenW'(1))) state_d = StDrain;
            end
         end
         StDrain: begin
            busy = 1'b1;
            if (hs && tlast) state_d = StDone;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin : p_data
      sr_d      = sr_q;
      beats_d   = beats_q;
      sr_last_d = sr_last_q;
      words_d   = words_q;
      if (accept) words_d = '0;
      if (load) begin
         sr_d      = load_data;
         beats_d   = BeatW'(BeatsPerWord);
         sr_last_d = (words_q + LenW'(1)) == len_q;
         words_d   = words_q + LenW'(1);
      end else if (hs) begin
         sr_d    = sr_q << TdataWidth;
         beats_d = beats_q - BeatW'(1);
      end
   end

   always_comb begin : p_fifo_ptr
      wptr_d  = fifo_wr ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
      count_d = count_q + CntW'(fifo_wr) - CntW'(pop);
   end

   always_ff @(posedge clk) begin : p_regs
      if (!rst_n) begin
         state_q       <= StIdle;
         len_q         <= '0;
         rd_addr_q     <= '0;
         rd_inflight_q <= 1'b0;
         words_q       <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
         sr_q          <= '0;
         beats_q       <= '0;
         sr_last_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         rd_addr_q     <= rd_addr_d;
         rd_inflight_q <= rd_en;
         words_q       <= words_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         count_q       <= count_d;
         sr_q          <= sr_d;
         beats_q       <= beats_d;
         sr_last_q     <= sr_last_d;
      end
   end

   always_ff @(posedge clk) begin : p_fifo_mem
      if (fifo_wr) fifo_q[wptr_q] <= outputs_mem_data_i;
   end

`ifdef AXIS_TX_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin : p_stall
      stall_d = stall_q;
      if (accept) begin
         stall_d = '0;
      end else if (busy && tvalid && !m_axis.tready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin : p_stall_reg
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign tx_stall_cnt_o = stall_q;
`endif

   assign outputs_mem_rd_en_o = rd_en;
   assign outputs_mem_addr_o  = rd_addr_q[MemAddrWidth-1:0];
   assign outputs_tx_busy_o   = busy;
   assign outputs_tx_done_o   = done;

   assign m_axis.tvalid = tvalid;
   assign m_axis.tdata  = sr_q[VlwWidth-1 -: TdataWidth];
   assign m_axis.tlast  = tlast;
   assign m_axis.tid    = tvalid ? OutputId : '0;

endmodule
